// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register for a multi-lane bundle, with a two-entry skid buffer,
// same-bundle WAW suppression, synchronous flush and a saturating stall counter.
module mem_wb_skid_reg #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned D_WIDTH   = 32,
    parameter int unsigned RA_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [LANES-1:0]             i_PCSrcM,
    input  logic [LANES-1:0]             i_RegWriteM,
    input  logic [LANES-1:0]             i_MemtoRegM,
    input  logic [LANES*D_WIDTH-1:0]     i_RD,
    input  logic [LANES*D_WIDTH-1:0]     i_ALUResultM,
    input  logic [LANES*RA_WIDTH-1:0]    i_WA3M,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [LANES-1:0]             o_PCSrcW,
    output logic [LANES-1:0]             o_RegWriteW,
    output logic [LANES-1:0]             o_MemtoRegW,
    output logic [LANES*D_WIDTH-1:0]     o_ReadDataW,
    output logic [LANES*D_WIDTH-1:0]     o_ALUOutW,
    output logic [LANES*RA_WIDTH-1:0]    o_WA3W,
    output logic [CNT_WIDTH-1:0]         o_stall_cnt
);

    localparam int unsigned DW = LANES * D_WIDTH;
    localparam int unsigned AW = LANES * RA_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_nxt;
    logic   valid_q, ready_q;
    logic   acc, dlv;
    logic   load_main_in, load_main_skid, load_skid_in, clr_main;

    logic [LANES-1:0] main_pc_q, main_rw_q, main_mtr_q;
    logic [DW-1:0]    main_rd_q, main_alu_q;
    logic [AW-1:0]    main_wa_q;
    logic [LANES-1:0] skid_pc_q, skid_rw_q, skid_mtr_q;
    logic [DW-1:0]    skid_rd_q, skid_alu_q;
    logic [AW-1:0]    skid_wa_q;
    logic [LANES-1:0] rw_waw;
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    assign acc = i_valid && ready_q;
    assign dlv = valid_q && i_ready;

    // Highest lane writing a given register keeps its write; lower lanes are dropped.
    always_comb begin
        rw_waw = i_RegWriteM;
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned j = i + 1; j < LANES; j++) begin
                if (i_RegWriteM[j] &&
                    (i_WA3M[j*RA_WIDTH +: RA_WIDTH] == i_WA3M[i*RA_WIDTH +: RA_WIDTH])) begin
                    rw_waw[i] = 1'b0;
                end
            end
        end
    end

    // Next-state and entry load selection; flush overrides everything.
    always_comb begin
        state_nxt      = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        clr_main       = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (acc && dlv) begin
                    load_main_in = 1'b1;
                end else if (acc) begin
                    state_nxt    = FULL;
                    load_skid_in = 1'b1;
                end else if (dlv) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (dlv) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (i_flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
        // Qualified control bits drop to zero whenever main becomes invalid.
        clr_main = (state_nxt == EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_nxt;
            valid_q <= (state_nxt != EMPTY);
            ready_q <= (state_nxt != FULL);
        end
    end

    // Main entry drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_pc_q  <= '0;
            main_rw_q  <= '0;
            main_mtr_q <= '0;
            main_rd_q  <= '0;
            main_alu_q <= '0;
            main_wa_q  <= '0;
        end else begin
            if (load_main_in) begin
                main_pc_q  <= i_PCSrcM;
                main_rw_q  <= rw_waw;
                main_mtr_q <= i_MemtoRegM;
                main_rd_q  <= i_RD;
                main_alu_q <= i_ALUResultM;
                main_wa_q  <= i_WA3M;
            end else if (load_main_skid) begin
                main_pc_q  <= skid_pc_q;
                main_rw_q  <= skid_rw_q;
                main_mtr_q <= skid_mtr_q;
                main_rd_q  <= skid_rd_q;
                main_alu_q <= skid_alu_q;
                main_wa_q  <= skid_wa_q;
            end
            if (clr_main) begin
                main_pc_q <= '0;
                main_rw_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_pc_q  <= '0;
            skid_rw_q  <= '0;
            skid_mtr_q <= '0;
            skid_rd_q  <= '0;
            skid_alu_q <= '0;
            skid_wa_q  <= '0;
        end else if (load_skid_in) begin
            skid_pc_q  <= i_PCSrcM;
            skid_rw_q  <= rw_waw;
            skid_mtr_q <= i_MemtoRegM;
            skid_rd_q  <= i_RD;
            skid_alu_q <= i_ALUResultM;
            skid_wa_q  <= i_WA3M;
        end
    end

    // Saturating count of cycles where WB back-pressures a valid bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (valid_q && !i_ready && !i_flush && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_PCSrcW    = main_pc_q;
    assign o_RegWriteW = main_rw_q;
    assign o_MemtoRegW = main_mtr_q;
    assign o_ReadDataW = main_rd_q;
    assign o_ALUOutW   = main_alu_q;
    assign o_WA3W      = main_wa_q;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg: streaming, back-pressure, WAW, flush, reset, saturation.
module tb_mem_wb_skid_reg;

    localparam int unsigned LANES = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_flush = 1'b0;
    logic                i_valid = 1'b0;
    logic                o_ready;
    logic [LANES-1:0]    i_PCSrcM = '0, i_RegWriteM = '0, i_MemtoRegM = '0;
    logic [LANES*DW-1:0] i_RD = '0, i_ALUResultM = '0;
    logic [LANES*AW-1:0] i_WA3M = '0;
    logic                o_valid;
    logic                i_ready = 1'b0;
    logic [LANES-1:0]    o_PCSrcW, o_RegWriteW, o_MemtoRegW;
    logic [LANES*DW-1:0] o_ReadDataW, o_ALUOutW;
    logic [LANES*AW-1:0] o_WA3W;
    logic [CW-1:0]       o_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_skid_reg #(.LANES(LANES), .D_WIDTH(DW), .RA_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_PCSrcM(i_PCSrcM), .i_RegWriteM(i_RegWriteM), .i_MemtoRegM(i_MemtoRegM),
        .i_RD(i_RD), .i_ALUResultM(i_ALUResultM), .i_WA3M(i_WA3M),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_PCSrcW(o_PCSrcW), .o_RegWriteW(o_RegWriteW), .o_MemtoRegW(o_MemtoRegW),
        .o_ReadDataW(o_ReadDataW), .o_ALUOutW(o_ALUOutW), .o_WA3W(o_WA3W),
        .o_stall_cnt(o_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_rd(input int k);
        return {32'h1000_0000 + 32'(k * 16 + 1), 32'h1000_0000 + 32'(k * 16)};
    endfunction

    function automatic logic [63:0] exp_alu(input int k);
        return {32'h2000_0000 + 32'(k * 16 + 1), 32'h2000_0000 + 32'(k * 16)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present bundle k: distinct write addresses 1/2, both lanes writing.
    task automatic drive(input int k);
        i_valid      = 1'b1;
        i_RD         = exp_rd(k);
        i_ALUResultM = exp_alu(k);
        i_WA3M       = {4'h2, 4'h1};
        i_RegWriteM  = 2'b11;
        i_PCSrcM     = 2'(k);
        i_MemtoRegM  = 2'(k + 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_cnt", 64'(o_stall_cnt), 64'd0);
        check("rst_rd", o_ReadDataW, 64'd0);
        check("rst_rw", 64'(o_RegWriteW), 64'd0);
        rst_n = 1'b1;

        // Streaming A,B,C with i_ready=1
        i_ready = 1'b1;
        drive(1); tick();
        check("str_valid_a", 64'(o_valid), 64'd1);
        check("str_rd_a", o_ReadDataW, exp_rd(1));
        check("str_pc_a", 64'(o_PCSrcW), 64'd1);
        check("str_rw_a", 64'(o_RegWriteW), 64'd3);
        drive(2); tick();
        check("str_alu_b", o_ALUOutW, exp_alu(2));
        check("str_mtr_b", 64'(o_MemtoRegW), 64'd3);
        check("str_ready_b", 64'(o_ready), 64'd1);
        drive(3); tick();
        check("str_rd_c", o_ReadDataW, exp_rd(3));
        check("str_wa_c", 64'(o_WA3W), 64'h21);
        i_valid = 1'b0; tick();
        check("str_drain", 64'(o_valid), 64'd0);
        check("str_cnt", 64'(o_stall_cnt), 64'd0);

        // Back-pressure: A held, B in skid, C held upstream
        do_reset();
        drive(4); tick();
        check("bp_rd_a", o_ReadDataW, exp_rd(4));
        i_ready = 1'b0;
        drive(5); tick();
        check("bp_hold_a1", o_ReadDataW, exp_rd(4));
        check("bp_ready0", 64'(o_ready), 64'd0);
        drive(6); tick();
        check("bp_hold_a2", o_ReadDataW, exp_rd(4));
        tick();
        check("bp_hold_a3", o_ReadDataW, exp_rd(4));
        check("bp_cnt3", 64'(o_stall_cnt), 64'd3);
        i_ready = 1'b1; tick();
        check("bp_rd_b", o_ReadDataW, exp_rd(5));
        check("bp_ready1", 64'(o_ready), 64'd1);
        tick();
        check("bp_rd_c", o_ReadDataW, exp_rd(6));
        check("bp_valid_c", 64'(o_valid), 64'd1);
        i_valid = 1'b0; tick();
        check("bp_drain", 64'(o_valid), 64'd0);
        check("bp_cnt_final", 64'(o_stall_cnt), 64'd3);

        // WAW suppression
        drive(7); i_WA3M = {4'h5, 4'h5}; tick();
        check("waw_same", 64'(o_RegWriteW), 64'h2);
        check("waw_data", o_ReadDataW, exp_rd(7));
        drive(8); i_WA3M = {4'h6, 4'h5}; tick();
        check("waw_diff", 64'(o_RegWriteW), 64'h3);
        drive(9); i_WA3M = {4'h5, 4'h5}; i_RegWriteM = 2'b01; tick();
        check("waw_hi_off", 64'(o_RegWriteW), 64'h1);
        i_valid = 1'b0; tick();

        // Flush while FULL with an incoming bundle
        i_ready = 1'b0;
        drive(10); tick();
        drive(11); tick();
        check("fl_full", 64'(o_ready), 64'd0);
        drive(12); i_flush = 1'b1; tick();
        check("fl_valid", 64'(o_valid), 64'd0);
        check("fl_ready", 64'(o_ready), 64'd1);
        check("fl_rw", 64'(o_RegWriteW), 64'd0);
        check("fl_pc", 64'(o_PCSrcW), 64'd0);
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1; tick();
        check("fl_nodeliver", 64'(o_valid), 64'd0);
        drive(13); tick();
        check("fl_next", o_ReadDataW, exp_rd(13));
        i_valid = 1'b0; tick();

        // Asynchronous reset while FULL
        i_ready = 1'b0;
        drive(14); tick();
        drive(15); tick();
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(o_valid), 64'd0);
        check("ar_ready", 64'(o_ready), 64'd1);
        check("ar_rd", o_ReadDataW, 64'd0);
        check("ar_alu", o_ALUOutW, 64'd0);
        check("ar_wa", 64'(o_WA3W), 64'd0);
        check("ar_rw", 64'(o_RegWriteW), 64'd0);
        check("ar_cnt", 64'(o_stall_cnt), 64'd0);
        i_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(16); tick();
        check("ar_first_valid", 64'(o_valid), 64'd1);
        check("ar_first_rd", o_ReadDataW, exp_rd(16));

        // Counter saturation at 15 with CNT_WIDTH=4
        i_valid = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        check("sat_15", 64'(o_stall_cnt), 64'd15);
        tick();
        tick();
        check("sat_hold", 64'(o_stall_cnt), 64'd15);
        check("sat_valid", 64'(o_valid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid_reg.md
# mem_wb_skid_reg

Parametrised MEM→WB pipeline register for the multi-lane (superscalar) core. It carries a bundle of LANES memory-stage results into write-back under a valid/ready handshake. A two-entry skid buffer lets the bundle path stall without a combinational ready path. Each captured bundle gets a synchronous flush and same-bundle write-after-write suppression, and the block keeps a saturating back-pressure counter.

## Interface
- LANES, 2, number of lanes per bundle (≥1)
- D_WIDTH, 32, data width of read data and ALU result
- RA_WIDTH, 4, register address width
- CNT_WIDTH, 16, width of the stall counter
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_flush  in  1  synchronous flush; discards all held and incoming bundles
- i_valid  in  1  MEM side presents a bundle
- o_ready  out  1  block can accept a bundle (registered)
- i_PCSrcM, i_RegWriteM, i_MemtoRegM  in  LANES each  per-lane control bits
- i_RD, i_ALUResultM  in  LANES*D_WIDTH each  per-lane read data / ALU result
- i_WA3M  in  LANES*RA_WIDTH  per-lane write address
- o_valid  out  1  WB-side bundle valid
- i_ready  in  1  WB side accepts the bundle
- o_PCSrcW, o_RegWriteW, o_MemtoRegW  out  LANES each  per-lane control, qualified by o_valid
- o_ReadDataW, o_ALUOutW  out  LANES*D_WIDTH each  per-lane data
- o_WA3W  out  LANES*RA_WIDTH  per-lane write address
- o_stall_cnt  out  CNT_WIDTH  saturating count of back-pressure cycles

Lane i occupies bits [i*W +: W] of every packed bus.

## Operation
- Accept: i_valid && o_ready at a clock edge. Deliver: o_valid && i_ready at a clock edge.
- Storage:
  - main entry: drives the outputs.
  - skid entry: holds a second bundle.
  - Each entry has a valid bit.
- States (derived from the valid bits):
  - EMPTY (neither valid).
  - ONE (main valid only).
  - FULL (both valid).
- Transitions:
  - EMPTY: accept → ONE, main ← input.
  - ONE, accept and deliver → ONE, main ← input.
  - ONE, accept without deliver → FULL, skid ← input.
  - ONE, deliver without accept → EMPTY.
  - ONE, neither → hold.
  - FULL: accept impossible (o_ready=0); deliver → ONE, main ← skid.
- o_ready = !skid_valid (registered); o_valid = main_valid.
- WAW suppression at capture: lane i's stored RegWrite is cleared if any lane j>i in the same bundle has RegWrite=1 and identical WA3. The highest lane wins. Data fields are stored unchanged.
- Output qualification: o_PCSrcW and o_RegWriteW = stored bit AND o_valid. o_MemtoRegW, data and address outputs show stored contents and are don't-care when o_valid=0.
- Flush:
  - i_flush=1 at an edge clears both valid bits and sets o_ready=1.
  - The incoming bundle is dropped even if i_valid && o_ready.
  - Flush has priority over accept and deliver; a simultaneous deliver still counts as delivered by the WB side.
  - Payload registers are not cleared.
- Stall counter:
  - Increments each edge where o_valid && !i_ready && !i_flush.
  - Saturates at 2^CNT_WIDTH−1.
  - Cleared only by reset.

## Timing
- Latency: accepted bundle appears on outputs the next cycle when main was empty or delivering. Otherwise it waits in skid.
- Throughput: one bundle per cycle while i_ready=1.
- After a single i_ready=0 cycle with continuous input, o_ready falls the following cycle. At most one extra bundle is absorbed; none are lost.
- No combinational path from i_ready to o_ready.
- Reset (any time, including mid-transfer):
  - o_valid=0, o_ready=1.
  - All payload outputs 0, o_stall_cnt=0.
  - Both entries invalid.
  - First acceptance possible at the first edge after rst_n deasserts.

## Test plan
- Streaming: LANES=2, i_ready=1, bundles A,B,C on consecutive cycles.
  - Required: o_valid from cycle 1 with A, B, C in order.
  - Required: o_ready stays 1; o_stall_cnt=0.
- Back-pressure: i_ready=0 for 3 cycles while streaming A,B,C.
  - Required: A held on outputs; B stored in skid; o_ready=0 from the next cycle; C is held upstream.
  - Required: after i_ready=1, A, B, C are delivered, none lost or duplicated.
  - Required: o_stall_cnt=3.
- WAW suppression: lane0 and lane1 both RegWrite=1 with WA3=4'h5.
  - Required: o_RegWriteW=2'b10.
  - Required: with WA3 5 and 6, o_RegWriteW=2'b11.
- Flush in FULL state with i_valid=1.
  - Required next cycle: o_valid=0, o_ready=1, o_RegWriteW=0, o_PCSrcW=0.
  - Required: the flushed-cycle bundle is never delivered.
- Reset mid-operation: assert rst_n=0 asynchronously while FULL.
  - Required immediately: all outputs 0 and o_ready=1.
  - Required: after release, a new bundle is delivered one cycle after acceptance.
- Counter saturation: CNT_WIDTH=4, hold o_valid=1 and i_ready=0 for 20 cycles.
  - Required: o_stall_cnt=15 and stays there.
